bios_wdt_ctrl: RTL and testbench
================================

# bios_wdt_ctrl

BIOS watchdog controller in the CLK32768 domain, downstream of the BIOS WDT write decoder. It turns the decoder's five per-value toggle signals into keyed commands (unlock, arm/kick, disarm). It runs a seconds-resolution watchdog timer. On expiry it issues a held reset request and flips the BIOS boot-bank select, so the next boot comes from the alternate flash image.

## Interface
- `TIMEOUT_S`, default 180: reload value in seconds, legal range 1..255.
- `PRESCALE`, default 32768: CLK32768 cycles per second tick, legal range 2..32768.
- `RST_HOLD`, default 16: number of cycles `BiosWdtRstReq` is held high, legal range 1..255.
- `CLK32768`, input, 1 bit: 32.768 kHz clock. This is the only clock.
- `MainReset`, input, 1 bit: reset, asynchronous, active-high.
- `bCPUWrWdtRegSig`, input, 5 bits: toggle-per-write from the decoder, already registered in the CLK32768 domain.
  - bit0 = 0x55 written
  - bit1 = 0x29
  - bit2 = 0xFF
  - bit3 = 0xAA
  - bit4 = any other value
- `BiosWdtRstReq`, output, 1 bit: reset request, high for `RST_HOLD` cycles on expiry.
- `BiosBankSel`, output, 1 bit: boot flash bank select. Toggles on each expiry.
- `BiosWdtExpired`, output, 1 bit: sticky expiry flag.
- `BiosWdtRunning`, output, 1 bit: timer is armed.
- `WdtRemain`, output, 8 bits: seconds remaining. Reads 0 when disarmed.
- `WdtState`, output, 2 bits: run FSM state, encoded as DISARMED=0, RUN=1, HOLD=2.

## Operation
- **Event detection.**
  - A register `prevSig` samples `bCPUWrWdtRegSig`.
  - `evt = bCPUWrWdtRegSig ^ prevSig`. Each set bit is one write event.
  - When several bits are set in one cycle, only the highest-priority event is taken. Priority order: bit4 > bit2 > bit1 > bit3 > bit0.
- **Key FSM** (LOCKED=0, KEY1=1, OPEN=2):
  - LOCKED: 0x55 moves to KEY1. Any other event is ignored.
  - KEY1: 0xAA moves to OPEN. 0x55 stays in KEY1. Any other event moves to LOCKED.
  - OPEN: 0x29 issues an arm/kick command, then LOCKED. 0xFF issues a disarm command, then LOCKED. Any other event moves to LOCKED.
  - Net effect: every command requires the full sequence 55, AA, then 29 or FF.
- **Run FSM.**
  - DISARMED:
    - arm: load `WdtRemain=TIMEOUT_S`, clear the prescaler, go to RUN.
    - disarm: clear `BiosWdtExpired`.
  - RUN:
    - kick: reload `WdtRemain=TIMEOUT_S` and clear the prescaler.
    - disarm: set `WdtRemain=0`, go to DISARMED, clear `BiosWdtExpired`.
    - Prescaler: counts 0..PRESCALE-1 and wraps. On each wrap, `WdtRemain` decrements.
    - Expiry: a wrap while `WdtRemain==1` sets `WdtRemain=0`, sets `BiosWdtExpired`, toggles `BiosBankSel`, loads the hold counter with `RST_HOLD`, and goes to HOLD.
  - HOLD:
    - `BiosWdtRstReq=1`. The hold counter decrements each cycle.
    - When the hold counter reaches 0, go to DISARMED. With `BIOS_WDT_AUTOARM_EN`, go to RUN with a full reload instead.
    - All commands are ignored. The key FSM still advances.
- **Output decode.** `BiosWdtRunning` is high iff the run FSM is in RUN.
- **Arithmetic.**
  - Prescaler is 15 bits; the counter is 8 bits.
  - `WdtRemain` never underflows. A wrap when the value is 0 outside RUN has no effect.

## Timing
- **Reset values.**
  - All outputs are 0: `BiosBankSel=0`, `BiosWdtExpired=0`, `BiosWdtRstReq=0`, `WdtRemain=0`, `WdtState=DISARMED`.
  - The key FSM resets to LOCKED, the prescaler to 0, and `prevSig` to 0.
  - With `BIOS_WDT_AUTOARM_EN` defined: `WdtState=RUN`, `WdtRemain=TIMEOUT_S`, `BiosWdtRunning=1`.
- **Event latency.**
  - A toggle on input at edge N is detected at edge N+1, where the key FSM and command are applied.
  - The run FSM and outputs update at edge N+1 as well.
  - Net: the command is visible one cycle after the input changes.
- **Expiry latency.**
  - Expiry occurs exactly `TIMEOUT_S*PRESCALE` cycles after the arm/kick edge.
  - `BiosWdtRstReq` rises on that same edge and stays high for exactly `RST_HOLD` cycles.
- **Kick coinciding with the expiry wrap.** The kick wins: reload, no expiry.
- **Disarm coinciding with the expiry wrap.** The disarm wins.
- **Reset mid-operation.**
  - Asserting `MainReset` during HOLD drops `BiosWdtRstReq` immediately, with no clock needed.
  - `BiosBankSel` returns to 0. Bank persistence across reset is owned by the consuming logic.

## Configuration
- `BIOS_WDT_AUTOARM_EN`:
  - Defined: the timer is armed out of reset and re-arms automatically after HOLD. BIOS must kick it, or disarm it with a keyed command, to prevent bank switching.
  - Undefined: the timer starts DISARMED and arms only on a keyed 0x29 command.

## Test plan
All scenarios use `PRESCALE=4`, `TIMEOUT_S=3`, `RST_HOLD=5`, macro undefined unless noted.
- **Keyed arm.** Toggle bit0, bit3, bit1 on separate cycles. Required: `WdtState=1` and `WdtRemain=3` one cycle after the bit1 toggle. `BiosWdtRstReq` rises exactly 12 cycles later, stays high 5 cycles, then `WdtState=0`, `BiosBankSel=1`, `BiosWdtExpired=1`.
- **Broken sequence.** Toggle bit0, bit4, bit3, bit1. Required: the timer stays DISARMED and `WdtRemain=0`.
- **Kick.** Arm, wait 10 cycles, then send 55/AA/29. Required: `WdtRemain` reloads to 3, and expiry occurs 12 cycles after the kick, not the arm.
- **Disarm.** After one expiry, send 55/AA/FF. Required: `BiosWdtExpired` clears, `BiosBankSel` stays 1, and a second expiry sets it back to 0.
- **Simultaneous toggles.** In OPEN, toggle bit1 and bit2 in the same cycle. Required: disarm is taken and the key FSM goes to LOCKED. Also assert `MainReset` during HOLD: `BiosWdtRstReq` falls asynchronously.
- **Autoarm.** With `BIOS_WDT_AUTOARM_EN` defined, release reset with no writes. Required: `BiosWdtRstReq` at cycle 12, and `WdtState=1` again 5 cycles later.

Source files
------------

// File: rtl/bios_wdt_ctrl.sv
// BIOS watchdog controller: keyed command decode, seconds timer, held reset request and boot-bank flip.
// Define BIOS_WDT_AUTOARM_EN to arm out of reset and re-arm automatically after each reset hold.
module bios_wdt_ctrl #(
    parameter int TIMEOUT_S = 180,
    parameter int PRESCALE  = 32768,
    parameter int RST_HOLD  = 16
) (
    input  logic       CLK32768,
    input  logic       MainReset,
    input  logic [4:0] bCPUWrWdtRegSig,
    output logic       BiosWdtRstReq,
    output logic       BiosBankSel,
    output logic       BiosWdtExpired,
    output logic       BiosWdtRunning,
    output logic [7:0] WdtRemain,
    output logic [1:0] WdtState
);

    typedef enum logic [1:0] {
        RUN_DISARMED = 2'd0,
        RUN_RUN      = 2'd1,
        RUN_HOLD     = 2'd2
    } runState_t;

    typedef enum logic [1:0] {
        KEY_LOCKED = 2'd0,
        KEY_KEY1   = 2'd1,
        KEY_OPEN   = 2'd2
    } keyState_t;

    localparam logic [2:0]  EV_NONE   = 3'd0;
    localparam logic [2:0]  EV_55     = 3'd1;
    localparam logic [2:0]  EV_29     = 3'd2;
    localparam logic [2:0]  EV_FF     = 3'd3;
    localparam logic [2:0]  EV_AA     = 3'd4;
    localparam logic [2:0]  EV_OTHER  = 3'd5;

    localparam logic [7:0]  TIMEOUT_V = 8'(TIMEOUT_S);
    localparam logic [7:0]  HOLD_V    = 8'(RST_HOLD);
    localparam logic [14:0] PRE_MAX   = 15'(PRESCALE - 1);

    // Only the highest-priority write of a cycle is acted on: other > FF > 29 > AA > 55.
    function automatic logic [2:0] pickEvent(input logic [4:0] evt);
        logic [2:0] code;
        if (evt[4]) begin
            code = EV_OTHER;
        end else if (evt[2]) begin
            code = EV_FF;
        end else if (evt[1]) begin
            code = EV_29;
        end else if (evt[3]) begin
            code = EV_AA;
        end else if (evt[0]) begin
            code = EV_55;
        end else begin
            code = EV_NONE;
        end
        return code;
    endfunction

    logic [4:0]  prevSig_r;
    keyState_t   keyState_r, keyNext_s;
    runState_t   runState_r, runNext_s;
    logic [14:0] preCnt_r, preNext_s;
    logic [7:0]  remain_r, remainNext_s;
    logic [7:0]  holdCnt_r, holdNext_s;
    logic        expired_r, expiredNext_s;
    logic        bankSel_r, bankNext_s;
    logic        rstReq_r, rstReqNext_s;
    logic        running_r, runningNext_s;
    logic [4:0]  evt_s;
    logic [2:0]  evCode_s;
    logic        armCmd_s, disarmCmd_s, preWrap_s;

    assign evt_s     = bCPUWrWdtRegSig ^ prevSig_r;
    assign evCode_s  = pickEvent(evt_s);
    assign preWrap_s = (preCnt_r == PRE_MAX);

    // State and datapath registers; reset request drops asynchronously with MainReset
    always_ff @(posedge CLK32768 or posedge MainReset) begin
        if (MainReset) begin
            prevSig_r  <= 5'd0;
            keyState_r <= KEY_LOCKED;
            preCnt_r   <= 15'd0;
            holdCnt_r  <= 8'd0;
            expired_r  <= 1'b0;
            bankSel_r  <= 1'b0;
            rstReq_r   <= 1'b0;
`ifdef BIOS_WDT_AUTOARM_EN
            runState_r <= RUN_RUN;
            remain_r   <= TIMEOUT_V;
            running_r  <= 1'b1;
`else
            runState_r <= RUN_DISARMED;
            remain_r   <= 8'd0;
            running_r  <= 1'b0;
`endif
        end else begin
            prevSig_r  <= bCPUWrWdtRegSig;
            keyState_r <= keyNext_s;
            runState_r <= runNext_s;
            preCnt_r   <= preNext_s;
            remain_r   <= remainNext_s;
            holdCnt_r  <= holdNext_s;
            expired_r  <= expiredNext_s;
            bankSel_r  <= bankNext_s;
            rstReq_r   <= rstReqNext_s;
            running_r  <= runningNext_s;
        end
    end

    // Key sequence next state: 55, AA, then 29 or FF
    always_comb begin
        keyNext_s = keyState_r;
        case (keyState_r)
            KEY_LOCKED: begin
                if (evCode_s == EV_55) keyNext_s = KEY_KEY1;
                else                   keyNext_s = KEY_LOCKED;
            end
            KEY_KEY1: begin
                if (evCode_s == EV_AA)                               keyNext_s = KEY_OPEN;
                else if ((evCode_s == EV_55) || (evCode_s == EV_NONE)) keyNext_s = KEY_KEY1;
                else                                                 keyNext_s = KEY_LOCKED;
            end
            KEY_OPEN: begin
                if (evCode_s == EV_NONE) keyNext_s = KEY_OPEN;
                else                     keyNext_s = KEY_LOCKED;
            end
            default: keyNext_s = KEY_LOCKED;
        endcase
    end

    // Commands decoded from the completed key sequence
    always_comb begin
        armCmd_s    = 1'b0;
        disarmCmd_s = 1'b0;
        if (keyState_r == KEY_OPEN) begin
            armCmd_s    = (evCode_s == EV_29);
            disarmCmd_s = (evCode_s == EV_FF);
        end else begin
            armCmd_s    = 1'b0;
            disarmCmd_s = 1'b0;
        end
    end

    // Run FSM next state and timer datapath; commands take precedence over the expiry wrap
    always_comb begin
        runNext_s     = runState_r;
        remainNext_s  = remain_r;
        holdNext_s    = holdCnt_r;
        expiredNext_s = expired_r;
        bankNext_s    = bankSel_r;
        preNext_s     = preWrap_s ? 15'd0 : (preCnt_r + 15'd1);
        case (runState_r)
            RUN_DISARMED: begin
                if (armCmd_s) begin
                    runNext_s    = RUN_RUN;
                    remainNext_s = TIMEOUT_V;
                    preNext_s    = 15'd0;
                end else if (disarmCmd_s) begin
                    expiredNext_s = 1'b0;
                end else begin
                    remainNext_s = 8'd0;
                end
            end
            RUN_RUN: begin
                if (armCmd_s) begin
                    remainNext_s = TIMEOUT_V;
                    preNext_s    = 15'd0;
                end else if (disarmCmd_s) begin
                    runNext_s     = RUN_DISARMED;
                    remainNext_s  = 8'd0;
                    expiredNext_s = 1'b0;
                end else if (preWrap_s) begin
                    if (remain_r > 8'd1) begin
                        remainNext_s = remain_r - 8'd1;
                    end else begin
                        runNext_s     = RUN_HOLD;
                        remainNext_s  = 8'd0;
                        expiredNext_s = 1'b1;
                        bankNext_s    = ~bankSel_r;
                        holdNext_s    = HOLD_V;
                    end
                end else begin
                    remainNext_s = remain_r;
                end
            end
            RUN_HOLD: begin
                if (holdCnt_r <= 8'd1) begin
                    holdNext_s = 8'd0;
`ifdef BIOS_WDT_AUTOARM_EN
                    runNext_s    = RUN_RUN;
                    remainNext_s = TIMEOUT_V;
                    preNext_s    = 15'd0;
`else
                    runNext_s    = RUN_DISARMED;
`endif
                end else begin
                    holdNext_s = holdCnt_r - 8'd1;
                end
            end
            default: begin
                runNext_s    = RUN_DISARMED;
                remainNext_s = 8'd0;
                holdNext_s   = 8'd0;
            end
        endcase
    end

    // Output decode from the next run state so registered outputs align with WdtState
    always_comb begin
        rstReqNext_s  = 1'b0;
        runningNext_s = 1'b0;
        case (runNext_s)
            RUN_RUN:  runningNext_s = 1'b1;
            RUN_HOLD: rstReqNext_s  = 1'b1;
            default: begin
                rstReqNext_s  = 1'b0;
                runningNext_s = 1'b0;
            end
        endcase
    end

    assign BiosWdtRstReq  = rstReq_r;
    assign BiosBankSel    = bankSel_r;
    assign BiosWdtExpired = expired_r;
    assign BiosWdtRunning = running_r;
    assign WdtRemain      = remain_r;
    assign WdtState       = runState_r;

endmodule

// File: tb/tb_bios_wdt_ctrl.sv
// Bench for bios_wdt_ctrl: directed scenarios plus randomized writes, checked against a time-based model.
module tb_bios_wdt_ctrl;
    localparam int T = 3;
    localparam int P = 4;
    localparam int H = 5;
`ifdef BIOS_WDT_AUTOARM_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       CLK32768 = 1'b0;
    logic       MainReset = 1'b1;
    logic [4:0] sig = 5'd0;
    logic       BiosWdtRstReq, BiosBankSel, BiosWdtExpired, BiosWdtRunning;
    logic [7:0] WdtRemain;
    logic [1:0] WdtState;

    bios_wdt_ctrl #(.TIMEOUT_S(T), .PRESCALE(P), .RST_HOLD(H)) dut (
        .CLK32768(CLK32768),
        .MainReset(MainReset),
        .bCPUWrWdtRegSig(sig),
        .BiosWdtRstReq(BiosWdtRstReq),
        .BiosBankSel(BiosBankSel),
        .BiosWdtExpired(BiosWdtExpired),
        .BiosWdtRunning(BiosWdtRunning),
        .WdtRemain(WdtRemain),
        .WdtState(WdtState)
    );

    always #5 CLK32768 = ~CLK32768;

    int    total = 0;
    int    bad = 0;
    string phase = "init";

    // Model: timer described by the edge on which it was (re)armed and the edge on which HOLD ends.
    int cyc, mRun, mArmCyc, mHoldEnd, mProg;
    bit mExp, mBank;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        cyc = 0; mProg = 0; mExp = 1'b0; mBank = 1'b0;
        mRun = AUTO ? 1 : 0; mArmCyc = 0; mHoldEnd = 0;
    endtask

    function automatic int expRemain();
        return (mRun == 1) ? (T - (cyc - mArmCyc) / P) : 0;
    endfunction

    function automatic int pickEv(input logic [4:0] t);
        if (t[4]) return 256;
        if (t[2]) return 'hFF;
        if (t[1]) return 'h29;
        if (t[3]) return 'hAA;
        if (t[0]) return 'h55;
        return -1;
    endfunction

    task automatic modelStep(input logic [4:0] t);
        int ev;
        bit arm, dis;
        cyc++;
        ev = pickEv(t);
        arm = 1'b0;
        dis = 1'b0;
        if (ev >= 0) begin
            if (mProg == 0)      mProg = (ev == 'h55) ? 1 : 0;
            else if (mProg == 1) mProg = (ev == 'hAA) ? 2 : ((ev == 'h55) ? 1 : 0);
            else begin
                arm = (ev == 'h29);
                dis = (ev == 'hFF);
                mProg = 0;
            end
        end
        if (mRun == 1) begin
            if (arm) mArmCyc = cyc;
            else if (dis) begin mRun = 0; mExp = 1'b0; end
            else if (cyc - mArmCyc == T * P) begin
                mRun = 2; mExp = 1'b1; mBank = ~mBank; mHoldEnd = cyc + H;
            end
        end else if (mRun == 2) begin
            if (cyc == mHoldEnd) begin
                if (AUTO) begin mRun = 1; mArmCyc = cyc; end
                else mRun = 0;
            end
        end else begin
            if (arm) begin mRun = 1; mArmCyc = cyc; end
            else if (dis) mExp = 1'b0;
        end
    endtask

    task automatic checkAll();
        check("state",   9'(WdtState),       9'(mRun));
        check("remain",  9'(WdtRemain),      9'(expRemain()));
        check("rstreq",  9'(BiosWdtRstReq),  9'(mRun == 2));
        check("running", 9'(BiosWdtRunning), 9'(mRun == 1));
        check("expired", 9'(BiosWdtExpired), 9'(mExp));
        check("bank",    9'(BiosBankSel),    9'(mBank));
    endtask

    task automatic tick(input logic [4:0] t);
        sig = sig ^ t;
        @(posedge CLK32768);
        modelStep(t);
        #1;
        checkAll();
    endtask

    task automatic cmd(input logic [4:0] last);
        tick(5'b00001);
        tick(5'b01000);
        tick(last);
    endtask

    initial begin
        int k;
        int r;
        modelReset();
        phase = "reset";
        repeat (3) @(posedge CLK32768);
        #1;
        checkAll();
        MainReset = 1'b0;
        modelReset();

`ifdef BIOS_WDT_AUTOARM_EN
        phase = "autoarm";
        repeat (11) tick(5'd0);
        check("pre_rst", 9'(BiosWdtRstReq), 9'd0);
        tick(5'd0);
        check("rst_at_12", 9'(BiosWdtRstReq), 9'd1);
        repeat (5) tick(5'd0);
        check("rearmed", 9'(WdtState), 9'd1);
`endif

        phase = "keyed_arm";
        cmd(5'b00010);
        check("arm_state", 9'(WdtState), 9'd1);
        check("arm_remain", 9'(WdtRemain), 9'd3);
        repeat (11) tick(5'd0);
        check("pre_expiry", 9'(BiosWdtRstReq), 9'd0);
        tick(5'd0);
        check("expiry_rst", 9'(BiosWdtRstReq), 9'd1);
        check("expiry_flag", 9'(BiosWdtExpired), 9'd1);
        repeat (4) tick(5'd0);
        check("hold_rst", 9'(BiosWdtRstReq), 9'd1);
        tick(5'd0);
        check("hold_end", 9'(BiosWdtRstReq), 9'd0);
        check("hold_end_state", 9'(WdtState), 9'(AUTO ? 1 : 0));

        phase = "broken";
        tick(5'b00001); tick(5'b10000); tick(5'b01000); tick(5'b00010);
`ifndef BIOS_WDT_AUTOARM_EN
        check("broken_state", 9'(WdtState), 9'd0);
        check("broken_remain", 9'(WdtRemain), 9'd0);
`endif

        phase = "kick";
        cmd(5'b00010);
        repeat (7) tick(5'd0);
        cmd(5'b00010);
        check("kick_remain", 9'(WdtRemain), 9'd3);
        repeat (11) tick(5'd0);
        check("kick_no_expiry", 9'(BiosWdtRstReq), 9'd0);
        tick(5'd0);
        check("kick_expiry", 9'(BiosWdtRstReq), 9'd1);
        repeat (5) tick(5'd0);

        phase = "disarm";
        cmd(5'b00100);
        check("dis_expired", 9'(BiosWdtExpired), 9'd0);
        check("dis_state", 9'(WdtState), 9'd0);
        cmd(5'b00010);
        repeat (12) tick(5'd0);
        check("second_expiry", 9'(BiosWdtRstReq), 9'd1);
        repeat (5) tick(5'd0);

        phase = "simultaneous";
        cmd(5'b00010);
        cmd(5'b00110);
        check("simul_disarm", 9'(WdtState), 9'd0);
        tick(5'b01000);
        tick(5'b00010);
        check("simul_locked", 9'(WdtState), 9'd0);

        phase = "reset_hold";
        cmd(5'b00010);
        repeat (12) tick(5'd0);
        check("in_hold", 9'(BiosWdtRstReq), 9'd1);
        MainReset = 1'b1;
        sig = 5'd0;
        #2;
        check("async_drop", 9'(BiosWdtRstReq), 9'd0);
        modelReset();
        checkAll();
        repeat (2) @(posedge CLK32768);
        #1;
        MainReset = 1'b0;

        phase = "random";
        k = 0;
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                repeat (14) tick(5'd0);
            end else if (r < 4) begin
                tick(5'd0);
            end else if (r == 4) begin
                tick(5'($urandom_range(0, 31)));
            end else begin
                if (k == 0)      tick(5'b00001);
                else if (k == 1) tick(5'b01000);
                else             tick(($urandom_range(0, 1) == 1) ? 5'b00010 : 5'b00100);
                k = (k == 2) ? 0 : k + 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
